wb_io_pattern_seq: RTL
======================

// Module: wb_io_pattern_seq
// PURPOSE
//  Wishbone-slave nibble sequencer that produces the 4-bit user I/O bus driven onto io_out[11:8] / io_oeb[11:8].
//  Firmware pushes nibbles into an 8-deep FIFO. A programmable prescaler pops one nibble per period onto io_out.
//  Sits directly upstream of the pad mapping in user_project_wrapper; the wrapper inverts wb_rst_i into wb_rst_ni.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  window base; the block decodes wbs_adr_i[31:8]==BASE_ADDR[31:8]
//  DEPTH      8              FIFO entries, power of two
//  DIV_W      16             prescaler width
// PORTS
//  wb_clk_i   in   1   sole clock
//  wb_rst_ni  in   1   asynchronous active-low reset
//  wbs_stb_i  in   1   WB strobe
//  wbs_cyc_i  in   1   WB cycle
//  wbs_we_i   in   1   WB write enable
//  wbs_sel_i  in   4   WB byte selects; sel[0] gates all writes (all fields sit in byte 0/1)
//  wbs_adr_i  in   32  WB address
//  wbs_dat_i  in   32  WB write data
//  wbs_ack_o  out  1   WB acknowledge
//  wbs_dat_o  out  32  WB read data
//  io_out     out  4   sequenced nibble
//  io_oeb     out  4   pad output-enable bar (0 = drive)
//  irq        out  1   level: FIFO empty while EN=1, or overrun/underrun sticky set
// BEHAVIOUR
//  Reset (async assert, sync release) gives:
//   ack=0, dat_o=0, io_out=0, io_oeb=4'hF, irq=0, FIFO empty, counter=0, FSM=IDLE.
//  Registers, offset = adr[7:2]*4:
//   0x00 CTRL    RW   [0] EN; [1] FLUSH (write-1, self-clears, reads 0)
//   0x04 OEB     RW   [3:0], reset F; copied straight to io_oeb
//   0x08 DIV     RW   [DIV_W-1:0], reset 0; period = DIV+1 cycles
//   0x0C DATA    WO   push wbs_dat_i[3:0]; reads 0
//   0x10 STATUS  R/W1C
//        [0] empty, [1] full, [7:4] count (saturates at 8 -> reads 8)
//        [8] underrun sticky, [9] overrun sticky; W1C on bits 8/9
//  WB handshake:
//   - ack is registered and asserts the cycle after stb&cyc&hit, for exactly 1 cycle.
//   - No new access is accepted while ack=1, so back-to-back accesses complete every 2 cycles.
//   - Register write, FIFO push and read-data capture happen on the accepting edge.
//   - dat_o is valid with ack and is 0 otherwise.
//   - An unmapped offset inside the window acks, reads 0 and ignores writes. An access outside the window gets no ack.
//  FSM IDLE/RUN:
//   - IDLE->RUN on EN=1; RUN->IDLE on EN=0. Leaving RUN clears the counter; io_out holds its last value.
//   - In RUN the counter increments every cycle; tick when cnt>=DIV, which also resets cnt to 0.
//   - ">=" makes a DIV shrink mid-count take effect at once. DIV=0 gives a tick every cycle.
//   - On tick with FIFO non-empty: pop, and io_out<=head on that edge (1-cycle pop-to-pin latency).
//   - On tick with FIFO empty: set underrun; io_out holds.
//  FIFO boundaries:
//   - Push when full: data dropped, overrun set.
//   - Push and tick in the same cycle: pop uses the pre-push state. When full, both succeed and count stays 8.
//     When empty, underrun is set and the pushed nibble is stored.
//   - FLUSH empties the FIFO; a push in the same write cycle is impossible (different offset).
//     Sticky bits and io_out are unaffected.
//  Reset mid-operation: everything returns to reset values immediately, including io_oeb -> F (pins tri-state).
// STRUCTURE
//  Package wb_io_pkg: register offset localparams (REG_CTRL..REG_STATUS), STATUS bit indices, FSM state encoding.
//  Sub-module nibble_fifo (DEPTH x 4, count output, push/pop/flush, full/empty).
//  Top holds the WB decode, register file, prescaler and FSM.
// TESTING
//  1 Reset: after release read STATUS -> 0x001; io_oeb=F; io_out=0; ack never seen for adr outside the window.
//  2 OEB=0, DIV=3, push 1,2,3, EN=1 -> io_out shows 1,2,3 at 4-cycle spacing; then underrun=1, io_out holds 3, irq=1.
//  3 Push 9 nibbles with EN=0 -> STATUS count=8, full=1, overrun=1; W1C 0x200 clears overrun only.
//  4 FIFO full, DIV=0, EN=1, push on a tick cycle -> count stays 8, no overrun; pin order preserved.
//  5 DIV=100 mid-count at cnt=50, write DIV=10 -> tick on the next cycle; subsequent period 11.
//  6 Running with 5 entries, write CTRL=0x3 -> FIFO empty next cycle, io_out unchanged, EN stays 1 -> underrun on next tick.
//    Also assert wb_rst_ni low mid-stream -> io_oeb=F asynchronously.

Source files
------------

// File: rtl/wb_io_pattern_seq_pkg.sv
// wb_io_pkg: register map, STATUS bit positions and sequencer state encoding.
package wb_io_pkg;
  localparam logic [5:0] REG_CTRL   = 6'h0;
  localparam logic [5:0] REG_OEB    = 6'h1;
  localparam logic [5:0] REG_DIV    = 6'h2;
  localparam logic [5:0] REG_DATA   = 6'h3;
  localparam logic [5:0] REG_STATUS = 6'h4;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_UNDER = 8;
  localparam int ST_OVER  = 9;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/wb_io_pattern_seq_fifo.sv
// nibble_fifo: DEPTH x 4 FIFO; a pop frees the slot a same-cycle push into a full FIFO needs.
module nibble_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [3:0]    din,
  output logic [3:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= din;
endmodule

// File: rtl/wb_io_pattern_seq.sv
// wb_io_pattern_seq: Wishbone slave that streams FIFO'd nibbles onto io_out at a programmable rate.
module wb_io_pattern_seq
  import wb_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8,
  parameter int          DIV_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oeb,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  logic en, acc, wr, push, flush, tick, pop, full, empty, under, over, w1c_under, w1c_over;
  logic [3:0] oeb, head;
  logic [AW:0] count;
  logic [DIV_W-1:0] div, cnt, cnt_d;
  logic [5:0] off;
  logic [31:0] status, rdata;
  state_t state, nxt;
  logic unused;
  assign unused = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:DIV_W]};
  assign acc       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr        = acc & wbs_we_i & wbs_sel_i[0];
  assign off       = wbs_adr_i[7:2];
  assign push      = wr & (off == REG_DATA);
  assign flush     = wr & (off == REG_CTRL) & wbs_dat_i[1];
  assign w1c_under = wr & (off == REG_STATUS) & wbs_dat_i[ST_UNDER];
  assign w1c_over  = wr & (off == REG_STATUS) & wbs_dat_i[ST_OVER];
  // a flush landing on a tick wins: nothing is popped and io_out holds
  assign pop       = tick & ~flush;
  assign status    = {22'b0, over, under, 4'(count), 2'b0, full, empty};
  assign rdata     = off == REG_CTRL   ? {31'b0, en} :
                     off == REG_OEB    ? {28'b0, oeb} :
                     off == REG_DIV    ? 32'(div) :
                     off == REG_STATUS ? status : 32'b0;
  assign io_oeb    = oeb;
  assign irq       = (en & empty) | under | over;
  nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .push(push), .pop(pop), .flush(flush),
    .din(wbs_dat_i[3:0]), .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    nxt   = en ? RUN : IDLE;
    tick  = state == RUN && en && cnt >= div;
    cnt_d = (state != RUN || !en || tick) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en        <= 1'b0;
      oeb       <= 4'hF;
      div       <= '0;
      under     <= 1'b0;
      over      <= 1'b0;
      io_out    <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
      if (wr && off == REG_CTRL) en <= wbs_dat_i[0];
      if (wr && off == REG_OEB) oeb <= wbs_dat_i[3:0];
      if (wr && off == REG_DIV) div <= wbs_dat_i[DIV_W-1:0];
      under <= (under & ~w1c_under) | (tick & empty);
      over  <= (over & ~w1c_over) | (push & full & ~pop);
      if (pop && !empty) io_out <= head;
    end
  end
endmodule
